// File: rtl/mips_div_arb_if.sv
// Handshake and divider bus shared by mips_div_arb and its neighbours.
// master: requesters plus divider side; slave: the arbiter.
interface mips_div_arb_if #(
  parameter int OPDATA_WIDTH = 32
);
  logic [1:0]                req_i;
  logic [1:0]                signed_i;
  logic [2*OPDATA_WIDTH-1:0] op1_i;
  logic [2*OPDATA_WIDTH-1:0] op2_i;
  logic [1:0]                flush_i;
  logic [1:0]                ack_o;
  logic                      rsp_valid_o;
  logic                      rsp_id_o;
  logic [2*OPDATA_WIDTH-1:0] rsp_result_o;
  logic                      div_start_o;
  logic                      div_annul_o;
  logic                      div_signed_o;
  logic [OPDATA_WIDTH-1:0]   div_op1_o;
  logic [OPDATA_WIDTH-1:0]   div_op2_o;
  logic [2*OPDATA_WIDTH-1:0] div_result_i;
  logic                      div_valid_i;
  logic                      timeout_o;

  modport master (
    output req_i, signed_i, op1_i, op2_i, flush_i,
    output div_result_i, div_valid_i,
    input  ack_o, rsp_valid_o, rsp_id_o, rsp_result_o,
    input  div_start_o, div_annul_o, div_signed_o,
    input  div_op1_o, div_op2_o, timeout_o
  );

  modport slave (
    input  req_i, signed_i, op1_i, op2_i, flush_i,
    input  div_result_i, div_valid_i,
    output ack_o, rsp_valid_o, rsp_id_o, rsp_result_o,
    output div_start_o, div_annul_o, div_signed_o,
    output div_op1_o, div_op2_o, timeout_o
  );
endinterface

// File: rtl/mips_div_arb.sv
// Two-requester round-robin arbiter in front of one shared divider.
// Define MIPS_DIV_ARB_TIMEOUT_EN to add the BUSY-state watchdog.
module mips_div_arb #(
  parameter int OPDATA_WIDTH = 32,
  parameter int TO_CNT_WIDTH = 7
) (
  input logic           clk,
  input logic           rst,
  mips_div_arb_if.slave bus
);
  localparam int W = OPDATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE,
    ANNUL
  } state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic           sgn_q, sgn_d;
  logic [W-1:0]   op1_q, op1_d;
  logic [W-1:0]   op2_q, op2_d;
  logic [2*W-1:0] res_q, res_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic           start_q, start_d;
  logic           annul_q, annul_d;

  logic [1:0]     eff;
  logic [1:0]     grant;
  logic           gnt_id;
  logic           own_flush;
  logic           to_hit;

  // Round-robin pick among live requests; grant only in IDLE.
  always_comb begin
    eff    = bus.req_i & ~bus.flush_i;
    gnt_id = 1'b0;
    case (eff)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_q;
      default: gnt_id = 1'b0;
    endcase
    grant = 2'b00;
    if (state_q == IDLE && eff != 2'b00 && !rst)
      grant[gnt_id] = 1'b1;
  end

  assign own_flush = owner_q ? bus.flush_i[1] : bus.flush_i[0];

  // Next-state and capture logic for the FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    sgn_d       = sgn_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    res_d       = res_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = BUSY;
          owner_d = gnt_id;
          last_d  = gnt_id;
          sgn_d   = gnt_id ? bus.signed_i[1]
                           : bus.signed_i[0];
          op1_d   = gnt_id ? bus.op1_i[2*W-1:W]
                           : bus.op1_i[W-1:0];
          op2_d   = gnt_id ? bus.op2_i[2*W-1:W]
                           : bus.op2_i[W-1:0];
        end
      end
      BUSY: begin
        if (own_flush) begin
          // A finished result is dropped, but the
          // divider still needs its release cycle.
          state_d = bus.div_valid_i ? RELEASE : ANNUL;
        end else if (bus.div_valid_i) begin
          state_d     = RELEASE;
          res_d       = bus.div_result_i;
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
        end else if (to_hit) begin
          state_d  = ANNUL;
          rsp_id_d = owner_q;
        end
      end
      RELEASE: state_d = IDLE;
      ANNUL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    start_d = (state_d == BUSY);
    annul_d = (state_d == ANNUL);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      sgn_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      start_q     <= 1'b0;
      annul_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      sgn_q       <= sgn_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      start_q     <= start_d;
      annul_q     <= annul_d;
    end
  end

`ifdef MIPS_DIV_ARB_TIMEOUT_EN
  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                    timeout_q, timeout_d;

  // Watchdog: counts BUSY cycles, zero on entry to BUSY.
  always_comb begin
    cnt_inc   = cnt_q + {{(TO_CNT_WIDTH-1){1'b0}}, 1'b1};
    cnt_d     = (state_q == BUSY) ? cnt_inc : '0;
    timeout_d = to_hit & ~own_flush & ~bus.div_valid_i;
  end

  assign to_hit = (state_q == BUSY) && (&cnt_inc);

  // Watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign to_hit        = 1'b0;
  assign bus.timeout_o = (TO_CNT_WIDTH < 0);
`endif

  assign bus.ack_o        = grant;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_result_o = res_q;
  assign bus.div_start_o  = start_q;
  assign bus.div_annul_o  = annul_q;
  assign bus.div_signed_o = sgn_q;
  assign bus.div_op1_o    = op1_q;
  assign bus.div_op2_o    = op2_q;
endmodule

// File: tb/tb_mips_div_arb.sv
// Self-checking bench for mips_div_arb with a divider stub.
// Table vectors, corner sequences, then randomized rounds.
module tb_mips_div_arb;
  logic clk;
  logic rst;

  mips_div_arb_if #(.OPDATA_WIDTH(32)) bus ();

  mips_div_arb #(
    .OPDATA_WIDTH(32),
    .TO_CNT_WIDTH(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [1:0]  pend;
  logic        sg[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  int          last;
  logic [63:0] last_res;
  int          dv_lat;
  int          dv_cnt;

  typedef struct {
    int          id;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic logic [63:0] ref_div(
      input logic s, input logic [31:0] x,
      input logic [31:0] y);
    longint sx, sy, q, r;
    if (y == 32'd0) return 64'd0;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // One clock; the divider stub reacts to div_start_o.
  task automatic tick();
    @(negedge clk);
    if (bus.div_start_o) begin
      dv_cnt++;
      if (dv_cnt >= dv_lat) begin
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = ref_div(bus.div_signed_o,
                                   bus.div_op1_o,
                                   bus.div_op2_o);
      end else begin
        bus.div_valid_i  = 1'b0;
        bus.div_result_i = {$urandom, $urandom};
      end
    end else begin
      dv_cnt           = 0;
      bus.div_valid_i  = 1'b0;
      bus.div_result_i = {$urandom, $urandom};
    end
  endtask

  task automatic drive_req();
    bus.req_i    = pend;
    bus.signed_i = {sg[1], sg[0]};
    bus.op1_i    = {a[1], a[0]};
    bus.op2_i    = {b[1], b[0]};
  endtask

  function automatic int pick(input logic [1:0] m);
    if (m == 2'b11) return (last == 0) ? 1 : 0;
    return m[1] ? 1 : 0;
  endfunction

  // mode 0: normal, 1: owner flush before done,
  // 2: owner flush together with div_valid_i.
  task automatic do_round(input int lat, input int mode,
                          input int f,
                          input logic [63:0] exp_in,
                          input bit has_exp);
    int          g;
    logic [63:0] exp;
    bit          done;
    drive_req();
    bus.flush_i = 2'b00;
    #1;
    g = pick(pend);
    chk("ack", {62'd0, bus.ack_o}, 64'd1 << g);
    exp = has_exp ? exp_in : ref_div(sg[g], a[g], b[g]);
    last    = g;
    pend[g] = 1'b0;
    dv_lat  = lat;
    tick();
    bus.req_i = pend;
    #1;
    chk("ack_busy", {62'd0, bus.ack_o}, 64'd0);
    chk("start", {63'd0, bus.div_start_o}, 64'd1);
    chk("op1", {32'd0, bus.div_op1_o}, {32'd0, a[g]});
    chk("op2", {32'd0, bus.div_op2_o}, {32'd0, b[g]});
    chk("sgn", {63'd0, bus.div_signed_o}, {63'd0, sg[g]});
    done = 1'b0;
    for (int k = 1; k <= 300 && !done; k++) begin
      bus.flush_i = 2'b00;
      if (mode != 0 && k == f) bus.flush_i[g] = 1'b1;
      if ($urandom_range(0, 3) == 0)
        bus.flush_i[1-g] = 1'b1;
      tick();
      bus.flush_i = 2'b00;
      #1;
      if (mode == 0 && k >= lat) begin
        done = 1'b1;
        chk("rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        chk("rsp_id", {63'd0, bus.rsp_id_o}, g);
        chk("rsp_result", bus.rsp_result_o, exp);
        chk("release", {61'd0, bus.div_start_o,
            bus.div_annul_o, |bus.ack_o}, 64'd0);
        last_res = exp;
      end else if (mode != 0 && k == f) begin
        done = 1'b1;
        chk("flush_end", {60'd0, bus.div_annul_o,
            bus.div_start_o, bus.rsp_valid_o,
            |bus.ack_o}, (f < lat) ? 64'h8 : 64'h0);
      end else begin
        chk("busy_hold", {61'd0, bus.div_start_o,
            bus.rsp_valid_o, |bus.ack_o}, 64'h4);
      end
    end
    if (!done) chk("round_bound", 64'd0, 64'd1);
    tick();
    #1;
    chk("idle", {61'd0, bus.div_start_o, bus.rsp_valid_o,
        bus.div_annul_o}, 64'd0);
    chk("rsp_hold", bus.rsp_result_o, last_res);
  endtask

  task automatic new_op(input int r);
    pend[r] = 1'b1;
    sg[r]   = 1'($urandom_range(0, 1));
    a[r]    = $urandom;
    b[r]    = ($urandom_range(0, 3) == 0) ?
              $urandom_range(0, 3) : $urandom;
  endtask

  task automatic drain();
    while (pend != 2'b00) do_round(2, 0, 0, 64'd0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int mode, lat, f;
    tbl[0] = '{0, 1'b0, 32'd100, 32'd7, 3,
               64'h00000002_0000000E};
    tbl[1] = '{1, 1'b1, 32'hFFFFFFF9, 32'd2, 4,
               64'hFFFFFFFF_FFFFFFFD};
    tbl[2] = '{0, 1'b0, 32'd5, 32'd0, 2, 64'd0};
    tbl[3] = '{1, 1'b0, 32'hFFFFFFFF, 32'd16, 1,
               64'h0000000F_0FFFFFFF};
    tbl[4] = '{0, 1'b1, 32'd7, 32'hFFFFFFFE, 5,
               64'h00000001_FFFFFFFD};
    tbl[5] = '{1, 1'b0, 32'd7, 32'hFFFFFFFE, 2,
               64'h00000007_00000000};

    pend = 2'b00;
    for (int r = 0; r < 2; r++) begin
      sg[r] = 1'b0; a[r] = 32'd0; b[r] = 32'd0;
    end
    last     = 1;
    last_res = 64'd0;
    dv_lat   = 1;
    dv_cnt   = 0;
    rst              = 1'b1;
    bus.req_i        = 2'b11;
    bus.signed_i     = 2'b11;
    bus.op1_i        = '1;
    bus.op2_i        = '1;
    bus.flush_i      = 2'b00;
    bus.div_valid_i  = 1'b0;
    bus.div_result_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", {62'd0, bus.ack_o}, 64'd0);
    chk("rst_ctl", {59'd0, bus.div_start_o,
        bus.div_annul_o, bus.div_signed_o,
        bus.rsp_valid_o, bus.rsp_id_o}, 64'd0);
    chk("rst_ops", {bus.div_op1_o, bus.div_op2_o}, 64'd0);
    chk("rst_res", bus.rsp_result_o, 64'd0);
    chk("rst_to", {63'd0, bus.timeout_o}, 64'd0);
    bus.req_i = 2'b00;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pend[tbl[i].id] = 1'b1;
      sg[tbl[i].id]   = tbl[i].sgn;
      a[tbl[i].id]    = tbl[i].a;
      b[tbl[i].id]    = tbl[i].b;
      do_round(tbl[i].lat, 0, 0, tbl[i].exp, 1'b1);
    end

    // Contention: 0, then 1 with 0 re-raised, then 0.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    last = 1;
    last_res = 64'd0;
    new_op(0);
    new_op(1);
    do_round(2, 0, 0, 64'd0, 1'b0);
    chk("rr_first", last, 0);
    new_op(0);
    do_round(3, 0, 0, 64'd0, 1'b0);
    chk("rr_second", last, 1);
    do_round(1, 0, 0, 64'd0, 1'b0);
    chk("rr_third", last, 0);

    // Owner flush five cycles into BUSY, then re-grant.
    pend[1] = 1'b1; sg[1] = 1'b1;
    a[1] = 32'hFFFFFFF9; b[1] = 32'd2;
    do_round(10, 1, 5, 64'd0, 1'b0);
    new_op(0);
    do_round(2, 0, 0, 64'd0, 1'b0);

    // Flush coincident with div_valid_i.
    new_op(0);
    do_round(3, 2, 3, 64'd0, 1'b0);
    new_op(1);
    do_round(1, 0, 0, 64'd0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1)
          new_op(r);
      if (pend == 2'b00) new_op(int'($urandom_range(0, 1)));
      mode = int'($urandom_range(0, 5));
      mode = (mode < 4) ? 0 : mode - 3;
      lat  = int'($urandom_range(1, 6));
      if (mode == 1 && lat < 2) lat = 2;
      f = (mode == 1) ? int'($urandom_range(1, lat - 1))
                      : lat;
      do_round(lat, mode, f, 64'd0, 1'b0);
    end
    drain();

    // Divider never answers.
    pend[1] = 1'b1; sg[1] = 1'b0;
    a[1] = 32'd9; b[1] = 32'd3;
    drive_req();
    #1;
    chk("stuck_ack", {62'd0, bus.ack_o}, 64'h2);
    last    = 1;
    pend[1] = 1'b0;
    dv_lat  = 1000000;
    tick();
    bus.req_i = 2'b00;
`ifdef MIPS_DIV_ARB_TIMEOUT_EN
    for (int k = 1; k <= 126; k++) begin
      tick();
      #1;
      chk("to_busy", {61'd0, bus.div_start_o,
          bus.timeout_o, bus.div_annul_o}, 64'h4);
    end
    tick();
    #1;
    chk("to_fire", {59'd0, bus.div_start_o,
        bus.timeout_o, bus.div_annul_o,
        bus.rsp_valid_o, bus.rsp_id_o}, 64'h0D);
`else
    for (int k = 1; k <= 200; k++) begin
      tick();
      #1;
      chk("stuck_busy", {62'd0, bus.div_start_o,
          bus.timeout_o}, 64'h2);
    end
    bus.flush_i[1] = 1'b1;
    tick();
    bus.flush_i = 2'b00;
    #1;
    chk("stuck_annul", {62'd0, bus.div_annul_o,
        bus.div_start_o}, 64'h2);
`endif
    tick();
    #1;
    chk("stuck_idle", {61'd0, bus.div_start_o,
        bus.timeout_o, bus.div_annul_o}, 64'd0);
    new_op(0);
    do_round(2, 0, 0, 64'd0, 1'b0);

    // Reset in the middle of a divide.
    new_op(0);
    drive_req();
    #1;
    chk("mid_ack", {62'd0, bus.ack_o}, 64'h1);
    last    = 0;
    pend[0] = 1'b0;
    dv_lat  = 50;
    tick();
    bus.req_i = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {60'd0, bus.div_start_o,
        bus.div_annul_o, bus.rsp_valid_o,
        bus.rsp_id_o}, 64'd0);
    chk("mid_rst_ops", {bus.div_op1_o, bus.div_op2_o},
        64'd0);
    chk("mid_rst_res", bus.rsp_result_o, 64'd0);
    tick();
    rst      = 1'b0;
    last     = 1;
    last_res = 64'd0;
    new_op(0);
    new_op(1);
    do_round(2, 0, 0, 64'd0, 1'b0);
    chk("mid_rr", last, 0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
